// File: rtl/dm_cmd_seq_if.sv
// DataMover command streams plus the S2MM write-completion strobe.
interface dm_cmd_seq_if;
    logic [71:0] m_axis_mm2s_cmd_tdata;
    logic        m_axis_mm2s_cmd_tvalid;
    logic        m_axis_mm2s_cmd_tready;
    logic [71:0] m_axis_s2mm_cmd_tdata;
    logic        m_axis_s2mm_cmd_tvalid;
    logic        m_axis_s2mm_cmd_tready;
    logic        s2mm_wr_xfer_cmplt;

    // Sequencer side: drives commands, observes ready and completion.
    modport master (
        output m_axis_mm2s_cmd_tdata,
        output m_axis_mm2s_cmd_tvalid,
        input  m_axis_mm2s_cmd_tready,
        output m_axis_s2mm_cmd_tdata,
        output m_axis_s2mm_cmd_tvalid,
        input  m_axis_s2mm_cmd_tready,
        input  s2mm_wr_xfer_cmplt
    );

    // DataMover side.
    modport slave (
        input  m_axis_mm2s_cmd_tdata,
        input  m_axis_mm2s_cmd_tvalid,
        output m_axis_mm2s_cmd_tready,
        input  m_axis_s2mm_cmd_tdata,
        input  m_axis_s2mm_cmd_tvalid,
        output m_axis_s2mm_cmd_tready,
        output s2mm_wr_xfer_cmplt
    );
endinterface

// File: rtl/dm_cmd_seq.sv
// Splits a memory-to-memory copy into DataMover command pairs of at most
// MAX_CHUNK bytes, one chunk in flight at a time.
module dm_cmd_seq #(
    parameter int unsigned MAX_CHUNK = 32'd4194304
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] saddr,
    input  logic [31:0] daddr,
    input  logic [31:0] btt,
    output logic        ready,
    output logic        done,
    output logic        err_unexp,
    output logic [15:0] chunk_cnt,
    dm_cmd_seq_if.master cmd
);

    localparam int unsigned AW   = 32;
    localparam int unsigned CW   = 72;
    localparam int unsigned LW   = 23;
    localparam int unsigned TAGW = 4;
    localparam int unsigned CNTW = 16;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t state_q, state_d;

    logic [AW-1:0]   cur_s_q, cur_s_d;
    logic [AW-1:0]   cur_d_q, cur_d_d;
    logic [AW-1:0]   rem_q, rem_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic            mm2s_valid_q, mm2s_valid_d;
    logic            s2mm_valid_q, s2mm_valid_d;
    logic [CW-1:0]   mm2s_data_q, mm2s_data_d;
    logic [CW-1:0]   s2mm_data_q, s2mm_data_d;

    logic [AW-1:0]   chunk_c;
    logic [AW-1:0]   rem_next_c;
    logic [LW-1:0]   first_len_c;
    logic [LW-1:0]   next_len_c;
    logic            m_acc_c;
    logic            s_acc_c;
    logic            cmplt_c;

    // Fixed-format DataMover command: INCR, EOF, no DRR, DSA=0.
    function automatic logic [CW-1:0] mk_cmd(input logic [AW-1:0]   addr,
                                             input logic [LW-1:0]   len,
                                             input logic [TAGW-1:0] tag);
        return {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, len};
    endfunction

    // Chunk sizing and handshake qualifiers.
    always_comb begin
        chunk_c     = (rem_q > AW'(MAX_CHUNK)) ? AW'(MAX_CHUNK) : rem_q;
        rem_next_c  = rem_q - chunk_c;
        first_len_c = (btt > AW'(MAX_CHUNK)) ? LW'(MAX_CHUNK) : LW'(btt);
        next_len_c  = (rem_next_c > AW'(MAX_CHUNK)) ? LW'(MAX_CHUNK) : LW'(rem_next_c);
        m_acc_c     = !mm2s_valid_q || cmd.m_axis_mm2s_cmd_tready;
        s_acc_c     = !s2mm_valid_q || cmd.m_axis_s2mm_cmd_tready;
        cmplt_c     = cmd.s2mm_wr_xfer_cmplt;
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (btt == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (m_acc_c && s_acc_c) state_d = S_WAIT;
            S_WAIT:  if (cmplt_c) state_d = (rem_next_c == '0) ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; commands are built together with the
    // ISSUE entry so tvalid and tdata rise on the same edge.
    always_comb begin
        cur_s_d      = cur_s_q;
        cur_d_d      = cur_d_q;
        rem_d        = rem_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        mm2s_valid_d = mm2s_valid_q;
        s2mm_valid_d = s2mm_valid_q;
        mm2s_data_d  = mm2s_data_q;
        s2mm_data_d  = s2mm_data_q;
        done_d       = (state_d == S_DONE);
        ready_d      = (state_d == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_s_d = saddr;
                    cur_d_d = daddr;
                    rem_d   = btt;
                    tag_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (btt != '0) begin
                        mm2s_valid_d = 1'b1;
                        s2mm_valid_d = 1'b1;
                        mm2s_data_d  = mk_cmd(saddr, first_len_c, '0);
                        s2mm_data_d  = mk_cmd(daddr, first_len_c, '0);
                    end
                end
                if (cmplt_c) err_d = 1'b1;
            end
            S_ISSUE: begin
                if (mm2s_valid_q && cmd.m_axis_mm2s_cmd_tready) mm2s_valid_d = 1'b0;
                if (s2mm_valid_q && cmd.m_axis_s2mm_cmd_tready) s2mm_valid_d = 1'b0;
                if (cmplt_c) err_d = 1'b1;
            end
            S_WAIT: begin
                if (cmplt_c) begin
                    cur_s_d = cur_s_q + chunk_c;
                    cur_d_d = cur_d_q + chunk_c;
                    rem_d   = rem_next_c;
                    tag_d   = tag_q + TAGW'(1);
                    cnt_d   = cnt_q + CNTW'(1);
                    if (rem_next_c != '0) begin
                        mm2s_valid_d = 1'b1;
                        s2mm_valid_d = 1'b1;
                        mm2s_data_d  = mk_cmd(cur_s_q + chunk_c, next_len_c, tag_q + TAGW'(1));
                        s2mm_data_d  = mk_cmd(cur_d_q + chunk_c, next_len_c, tag_q + TAGW'(1));
                    end
                end
            end
            S_DONE: begin
                if (cmplt_c) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cur_s_q      <= '0;
            cur_d_q      <= '0;
            rem_q        <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
            mm2s_valid_q <= 1'b0;
            s2mm_valid_q <= 1'b0;
            mm2s_data_q  <= '0;
            s2mm_data_q  <= '0;
        end else begin
            cur_s_q      <= cur_s_d;
            cur_d_q      <= cur_d_d;
            rem_q        <= rem_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            mm2s_valid_q <= mm2s_valid_d;
            s2mm_valid_q <= s2mm_valid_d;
            mm2s_data_q  <= mm2s_data_d;
            s2mm_data_q  <= s2mm_data_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign err_unexp = err_q;
    assign chunk_cnt = cnt_q;

    assign cmd.m_axis_mm2s_cmd_tdata  = mm2s_data_q;
    assign cmd.m_axis_mm2s_cmd_tvalid = mm2s_valid_q;
    assign cmd.m_axis_s2mm_cmd_tdata  = s2mm_data_q;
    assign cmd.m_axis_s2mm_cmd_tvalid = s2mm_valid_q;

endmodule
